// File: rtl/ethernet_tx_arbiter.sv
// Round-robin arbiter sharing one MAC TX byte bus between NUM_PORTS frame sources.
// Optional grant watchdog enabled by defining ETH_TX_ARBITER_WATCHDOG_EN.
module ethernet_tx_arbiter #(
  parameter int NUM_PORTS        = 4,
  parameter int WATCHDOG_TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   req,
  output logic [NUM_PORTS-1:0]   grant,
  input  logic [NUM_PORTS-1:0]   in_start,
  input  logic [NUM_PORTS-1:0]   in_data_valid,
  input  logic [8*NUM_PORTS-1:0] in_data,
  input  logic [NUM_PORTS-1:0]   in_done,
  input  logic                   mac_tx_ready,
  output logic                   mac_tx_start,
  output logic                   mac_tx_data_valid,
  output logic [7:0]             mac_tx_data,
  output logic                   watchdog_abort
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANTED    = 2'd1,
    WAIT_BUSY  = 2'd2,
    WAIT_READY = 2'd3
  } state_t;

  state_t               state_r;
  logic [NUM_PORTS-1:0] grant_r;
  logic [IDX_W-1:0]     last_winner_r;
  logic                 started_r;
  logic                 mac_tx_start_r;
  logic                 mac_tx_data_valid_r;
  logic [7:0]           mac_tx_data_r;
  logic                 watchdog_abort_r;

  logic                 found_s;
  logic [IDX_W-1:0]     winner_s;
  logic [IDX_W-1:0]     cand_s;
  logic                 g_start_s;
  logic                 g_valid_s;
  logic                 g_done_s;
  logic [7:0]           g_data_s;
  logic                 fwd_start_s;
  logic                 fwd_valid_s;
  logic                 expire_s;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin search starting just above the previous winner
  always_comb begin
    found_s  = 1'b0;
    winner_s = last_winner_r;
    cand_s   = last_winner_r;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand_s   = IDX_W'((int'(last_winner_r) + i) % NUM_PORTS);
      winner_s = (!found_s && req[cand_s]) ? cand_s : winner_s;
      found_s  = found_s | req[cand_s];
    end
  end

  // AND-OR select of the granted source; grant_r is one-hot or zero
  always_comb begin
    g_data_s = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++) begin
      g_data_s = g_data_s | (in_data[i*8 +: 8] & {8{grant_r[i]}});
    end
  end

  assign g_start_s   = |(in_start & grant_r);
  assign g_valid_s   = |(in_data_valid & grant_r);
  assign g_done_s    = |(in_done & grant_r);
  assign fwd_start_s = g_start_s & ~started_r;
  assign fwd_valid_s = g_valid_s & (started_r | g_start_s);

`ifdef ETH_TX_ARBITER_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_r;
  logic            activity_s;

  assign activity_s = g_start_s | g_valid_s | g_done_s;
  assign expire_s   = (state_r == GRANTED) && !activity_s &&
                      (wd_cnt_r == WD_W'(WATCHDOG_TIMEOUT - 1));

  // Idle-clock counter, cleared by any activity from the granted source
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_r <= '0;
    end else if (state_r != GRANTED || activity_s) begin
      wd_cnt_r <= '0;
    end else begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1'b1);
    end
  end
`else
  assign expire_s = 1'b0;
`endif

  // Arbitration FSM with registered grant and MAC-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r             <= IDLE;
      grant_r             <= '0;
      last_winner_r       <= IDX_W'(NUM_PORTS - 1);
      started_r           <= 1'b0;
      mac_tx_start_r      <= 1'b0;
      mac_tx_data_valid_r <= 1'b0;
      mac_tx_data_r       <= 8'h00;
      watchdog_abort_r    <= 1'b0;
    end else begin
      mac_tx_start_r      <= 1'b0;
      mac_tx_data_valid_r <= 1'b0;
      watchdog_abort_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mac_tx_ready && found_s) begin
            grant_r       <= onehot(winner_s);
            last_winner_r <= winner_s;
            started_r     <= 1'b0;
            state_r       <= GRANTED;
          end
        end
        GRANTED: begin
          mac_tx_start_r      <= fwd_start_s;
          mac_tx_data_valid_r <= fwd_valid_s;
          if (fwd_valid_s) begin
            mac_tx_data_r <= g_data_s;
          end
          if (fwd_start_s) begin
            started_r <= 1'b1;
          end
          // A frame that never started leaves nothing for the MAC to drain
          if (g_done_s || expire_s) begin
            grant_r          <= '0;
            watchdog_abort_r <= expire_s;
            state_r          <= (started_r || fwd_start_s) ? WAIT_BUSY : IDLE;
          end
        end
        WAIT_BUSY: begin
          if (!mac_tx_ready) begin
            state_r <= WAIT_READY;
          end
        end
        WAIT_READY: begin
          if (mac_tx_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end

  assign grant             = grant_r;
  assign mac_tx_start      = mac_tx_start_r;
  assign mac_tx_data_valid = mac_tx_data_valid_r;
  assign mac_tx_data       = mac_tx_data_r;
  assign watchdog_abort    = watchdog_abort_r;

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Self-checking bench for ethernet_tx_arbiter: vector table plus scoreboarded frame sequences.
module tb_ethernet_tx_arbiter;

  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   req;
  logic [NP-1:0]   grant;
  logic [NP-1:0]   in_start;
  logic [NP-1:0]   in_data_valid;
  logic [8*NP-1:0] in_data;
  logic [NP-1:0]   in_done;
  logic            mac_tx_ready;
  logic            mac_tx_start;
  logic            mac_tx_data_valid;
  logic [7:0]      mac_tx_data;
  logic            watchdog_abort;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sb_q[$];
  bit         sb_en = 1'b0;
  int         ff_seen = 0;
  int         abort_seen = 0;
  int         wd_n = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  start;
    logic [3:0]  valid;
    logic [3:0]  done;
    logic [31:0] data;
    logic        ready;
    logic [3:0]  e_grant;
    logic        e_start;
    logic        e_valid;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  ethernet_tx_arbiter #(
    .NUM_PORTS        (NP),
    .WATCHDOG_TIMEOUT (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .grant             (grant),
    .in_start          (in_start),
    .in_data_valid     (in_data_valid),
    .in_data           (in_data),
    .in_done           (in_done),
    .mac_tx_ready      (mac_tx_ready),
    .mac_tx_start      (mac_tx_start),
    .mac_tx_data_valid (mac_tx_data_valid),
    .mac_tx_data       (mac_tx_data),
    .watchdog_abort    (watchdog_abort)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge, byte outputs checked against the scoreboard
  task automatic tick();
    logic [7:0] exp_b;
    @(posedge clk);
    #1;
    if (watchdog_abort) abort_seen++;
    if (mac_tx_data_valid) begin
      if (mac_tx_data == 8'hFF) ff_seen++;
      if (sb_en) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %02h with nothing expected", mac_tx_data);
        end else begin
          exp_b = sb_q.pop_front();
          chk("sb_byte", {24'h0, mac_tx_data}, {24'h0, exp_b});
        end
      end
    end
  endtask

  task automatic clr();
    in_start      = '0;
    in_data_valid = '0;
    in_done       = '0;
    in_data       = '0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    clr();
    req          = '0;
    mac_tx_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input logic [3:0] exp, input string name);
    for (int i = 0; i < 10 && grant == '0; i++) tick();
    chk(name, {28'h0, grant}, {28'h0, exp});
  endtask

  task automatic noise_set(input int p);
    for (int i = 0; i < NP; i++) begin
      if (i != p) begin
        in_data_valid[i]  = 1'b1;
        in_data[i*8 +: 8] = 8'hFF;
        in_start[i]       = 1'b1;
      end
    end
  endtask

  // Granted port p sends start then n bytes; done either with the last byte or after it
  task automatic run_frame(input int p, input int n, input logic [7:0] b0,
                           input bit done_last, input bit noise);
    logic [7:0] b;
    clr();
    in_start[p] = 1'b1;
    if (noise) noise_set(p);
    tick();
    chk("start_pulse", {31'h0, mac_tx_start}, 32'h1);
    for (int k = 0; k < n; k++) begin
      clr();
      if (noise) noise_set(p);
      if (noise && k == 0) in_start = '1;
      b = 8'(b0 + 8'(k));
      in_data_valid[p]  = 1'b1;
      in_data[p*8 +: 8] = b;
      sb_q.push_back(b);
      if (done_last && k == n - 1) in_done[p] = 1'b1;
      tick();
      chk("start_single", {31'h0, mac_tx_start}, 32'h0);
    end
    if (!done_last) begin
      clr();
      in_done[p] = 1'b1;
      tick();
    end
    clr();
    chk("grant_release", {28'h0, grant}, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    //             req    start  valid  done   data          rdy   grant  st    vld   data
    tbl[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0001, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0001, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 32'h0000_0011, 1'b1, 4'b0001, 1'b0, 1'b1, 8'h11};
    tbl[3] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 32'h0000_0022, 1'b1, 4'b0001, 1'b0, 1'b1, 8'h22};
    tbl[4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h22};
    tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h22};
    tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h22};
    tbl[7] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0001, 1'b0, 1'b0, 8'h22};
    tbl[8] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h22};
    tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h22};

    // Reset state
    do_reset();
    chk("rst_grant", {28'h0, grant}, 32'h0);
    chk("rst_start", {31'h0, mac_tx_start}, 32'h0);
    chk("rst_valid", {31'h0, mac_tx_data_valid}, 32'h0);
    chk("rst_data", {24'h0, mac_tx_data}, 32'h0);
    chk("rst_abort", {31'h0, watchdog_abort}, 32'h0);

    // Single source frame, then a start-less grant, from the vector table
    for (int k = 0; k < 10; k++) begin
      req           = tbl[k].req;
      in_start      = tbl[k].start;
      in_data_valid = tbl[k].valid;
      in_done       = tbl[k].done;
      in_data       = tbl[k].data;
      mac_tx_ready  = tbl[k].ready;
      tick();
      chk($sformatf("tbl%0d_grant", k), {28'h0, grant}, {28'h0, tbl[k].e_grant});
      chk($sformatf("tbl%0d_start", k), {31'h0, mac_tx_start}, {31'h0, tbl[k].e_start});
      chk($sformatf("tbl%0d_valid", k), {31'h0, mac_tx_data_valid}, {31'h0, tbl[k].e_valid});
      chk($sformatf("tbl%0d_data", k), {24'h0, mac_tx_data}, {24'h0, tbl[k].e_data});
      chk($sformatf("tbl%0d_abort", k), {31'h0, watchdog_abort}, 32'h0);
    end
    clr();

    // Contention: four frames, round-robin order gated by the ready fall/rise
    do_reset();
    sb_en = 1'b1;
    req   = 4'hF;
    for (int f = 0; f < 4; f++) begin
      wait_grant(4'(1 << f), $sformatf("rr_grant%0d", f));
      run_frame(f, 2, 8'(8'h40 + 8'(f * 16)), f[0], 1'b0);
      repeat (3) tick();
      chk("no_grant_while_busy", {28'h0, grant}, 32'h0);
      mac_tx_ready = 1'b0;
      tick();
      chk("no_grant_ready_low", {28'h0, grant}, 32'h0);
      mac_tx_ready = 1'b1;
    end
    req = '0;
    repeat (3) tick();

    // Isolation: noise from other ports, early valid, req withdrawn mid-grant
    do_reset();
    ff_seen = 0;
    req     = 4'b0010;
    wait_grant(4'b0010, "iso_grant");
    req              = 4'b0000;
    in_data_valid[1] = 1'b1;
    in_data[15:8]    = 8'h33;
    tick();
    chk("pre_start_drop", {31'h0, mac_tx_data_valid}, 32'h0);
    chk("req_drop_hold", {28'h0, grant}, 32'h2);
    run_frame(1, 3, 8'hA0, 1'b0, 1'b1);
    chk("isolation_ff", ff_seen, 0);

    // Done before start returns straight to IDLE and passes to port 3
    do_reset();
    req = 4'b0100;
    wait_grant(4'b0100, "abort_grant2");
    req        = 4'b1100;
    in_done[2] = 1'b1;
    tick();
    clr();
    chk("abort_grant_drop", {28'h0, grant}, 32'h0);
    chk("abort_no_start", {31'h0, mac_tx_start}, 32'h0);
    tick();
    chk("abort_regrant3", {28'h0, grant}, 32'h8);
    chk("abort_still_no_start", {31'h0, mac_tx_start}, 32'h0);

    // Port 3 stays silent while granted
    abort_seen = 0;
`ifdef ETH_TX_ARBITER_WATCHDOG_EN
    wd_n = 0;
    while (abort_seen == 0 && wd_n < 40) begin
      tick();
      wd_n++;
    end
    chk("wd_abort_cycle", wd_n, 16);
    chk("wd_grant_drop", {28'h0, grant}, 32'h0);
    tick();
    chk("wd_abort_single", {31'h0, watchdog_abort}, 32'h0);
`else
    repeat (40) tick();
    chk("wd_grant_held", {28'h0, grant}, 32'h8);
    chk("wd_no_abort", abort_seen, 0);
    in_done[3] = 1'b1;
    tick();
    clr();
    chk("wd_done_release", {28'h0, grant}, 32'h0);
`endif

    // Reset during byte 3 of a frame
    do_reset();
    req = 4'b0001;
    wait_grant(4'b0001, "midrst_grant");
    in_start[0] = 1'b1;
    tick();
    clr();
    for (int k = 1; k <= 2; k++) begin
      in_data_valid[0] = 1'b1;
      in_data[7:0]     = 8'(k);
      sb_q.push_back(8'(k));
      tick();
      clr();
    end
    in_data_valid[0] = 1'b1;
    in_data[7:0]     = 8'h03;
    reset            = 1'b1;
    tick();
    chk("midrst_grant0", {28'h0, grant}, 32'h0);
    chk("midrst_start0", {31'h0, mac_tx_start}, 32'h0);
    chk("midrst_valid0", {31'h0, mac_tx_data_valid}, 32'h0);
    chk("midrst_data0", {24'h0, mac_tx_data}, 32'h0);
    chk("midrst_abort0", {31'h0, watchdog_abort}, 32'h0);
    reset = 1'b0;
    clr();
    req = 4'hF;
    wait_grant(4'b0001, "midrst_first_winner");
    chk("midrst_no_start", {31'h0, mac_tx_start}, 32'h0);

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ethernet_tx_arbiter.md
ETHERNET_TX_ARBITER -- requirements
Module: ethernet_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of frame sources (2..8).
REQ-002 SHALL have parameter WATCHDOG_TIMEOUT, default 4096, maximum idle clocks while granted; used only when the Configuration macro is defined.
REQ-003 SHALL have port clk  input  1  single clock, the MAC TX clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_PORTS  per-source frame request, level.
REQ-006 SHALL have port grant  output  NUM_PORTS  one-hot ownership, held for the whole frame.
REQ-007 SHALL have port in_start  input  NUM_PORTS  per-source frame start pulse.
REQ-008 SHALL have port in_data_valid  input  NUM_PORTS  per-source byte strobe.
REQ-009 SHALL have port in_data  input  8*NUM_PORTS  per-source byte; port i occupies bits [8i+7:8i].
REQ-010 SHALL have port in_done  input  NUM_PORTS  per-source end-of-frame pulse.
REQ-011 SHALL have port mac_tx_ready  input  1  MAC tx_ready flag.
REQ-012 SHALL have port mac_tx_start  output  1  start pulse to the MAC TX bus.
REQ-013 SHALL have port mac_tx_data_valid  output  1  byte strobe to the MAC.
REQ-014 SHALL have port mac_tx_data  output  8  byte to the MAC.
REQ-015 SHALL have port watchdog_abort  output  1  one-cycle pulse on grant revocation.

Function
REQ-016 SHALL implement the states IDLE, GRANTED, WAIT_BUSY and WAIT_READY.
REQ-017 IDLE: when mac_tx_ready=1 and req!=0, SHALL select a winner round-robin, searching upward from last_winner+1 modulo NUM_PORTS.
- On selection: assert grant[winner] on the next clock, store last_winner and enter GRANTED.
REQ-018 GRANTED: SHALL forward only the granted port's in_start, in_data_valid and in_data to the mac_tx_* outputs, registered, with exactly 1 clock latency.
- Non-granted port inputs SHALL be ignored.
REQ-019 SHALL forward only the first in_start of a grant; later in_start pulses in the same grant SHALL be dropped.
REQ-020 SHALL drop in_data_valid from the granted port before its first in_start.
REQ-021 in_done on the granted port SHALL end the grant: grant=0 on the next clock.
- If a start was forwarded: go to WAIT_BUSY.
- If no start was forwarded: go to IDLE.
REQ-022 When in_done and in_data_valid occur in the same cycle, the byte SHALL still be forwarded.
REQ-023 WAIT_BUSY SHALL hold until mac_tx_ready=0, then go to WAIT_READY.
REQ-024 WAIT_READY SHALL hold until mac_tx_ready=1, then go to IDLE; no grant is issued in these states.
REQ-025 Deasserting req[i] while port i is granted SHALL NOT revoke the grant.
REQ-026 grant SHALL always be one-hot or zero.
REQ-027 mac_tx_start, mac_tx_data_valid and watchdog_abort SHALL be single-cycle pulses.
REQ-028 mac_tx_data SHALL hold its last value when mac_tx_data_valid=0.
REQ-029 Minimum re-arbitration gap after a forwarded frame is governed solely by the mac_tx_ready fall/rise sequence.

Reset
REQ-030 While reset=1, SHALL force the following on the next clock:
- state IDLE, grant=0, mac_tx_start=0, mac_tx_data_valid=0, mac_tx_data=0, watchdog_abort=0;
- last_winner=NUM_PORTS-1, so port 0 wins first;
- watchdog counter cleared.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no further output pulses; the MAC resynchronises via its own start-driven FIFO reset.

Configuration
REQ-032 The macro ETH_TX_ARBITER_WATCHDOG_EN SHALL control the grant watchdog.
- Defined, GRANTED: count clocks with no in_start, in_data_valid or in_done from the granted port; any of them clears the count.
- Defined, on reaching WATCHDOG_TIMEOUT: deassert grant, pulse watchdog_abort, and leave exactly as REQ-021 does.
- Not defined: no counter is built, watchdog_abort is tied 0, and a grant persists until in_done.

Verification
REQ-033 Single source: req=0001 with mac_tx_ready=1, then start plus bytes 0x11,0x22, then done -> grant=0001 after 1 clk; mac_tx_start and then 0x11,0x22 each 1 clk late; grant=0 after done.
REQ-034 Contention: req=1111 held for four frames -> grant order port 0,1,2,3, each new grant only after mac_tx_ready goes low then high.
REQ-035 Isolation: the non-granted port drives data_valid with 0xFF during port 1's frame -> 0xFF never appears on mac_tx_data.
REQ-036 Abort before start: grant to port 2, then in_done with no start -> IDLE next clk with no mac_tx_start; port 3 granted next if requesting.
REQ-037 Watchdog (macro defined, WATCHDOG_TIMEOUT=16): granted port silent for 16 clks -> watchdog_abort pulse and grant=0.
- Same stimulus without the macro -> grant held indefinitely.
REQ-038 Reset mid-frame: reset=1 during byte 3 of a frame -> all outputs 0 the next clk; after release, port 0 wins first.
